multicycle_control: RTL and testbench

Main sequencing FSM for the multicycle CPU. It drives the write enables of every architectural and intermediate register (PC, IR, A, B, ALUOut, MDR, register file), the datapath mux selects, the ALU op and the memory request handshake. Sequencing is decoded from the IR opcode/funct fields and the ALU zero flag. It sits beside the datapath and is the only block that asserts `wrenable` on datapath registers.

---
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multicycle CPU; optional JAL support via MULTICYCLE_CONTROL_JAL_EN
module multicycle_control #(
  parameter int unsigned max_wait = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       a_we,
  output logic       b_we,
  output logic       aluout_we,
  output logic       mdr_we,
  output logic       rf_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] rf_dst,
  output logic [1:0] rf_src,
  output logic [2:0] state,
  output logic       halted,
  output logic [1:0] fault_code
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  logic [2:0] r_state, w_next;
  logic [1:0] r_fault, w_fault;
  logic [7:0] r_wait;
  logic w_rtype, w_r_alu, w_jr, w_addi, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_legal, w_wait_hit;
  logic w_pc_we, w_ir_we, w_a_we, w_b_we, w_aluout_we, w_mdr_we, w_rf_we, w_mem_req, w_mem_we;
  assign w_rtype = opcode == 6'h00;
  assign w_r_alu = w_rtype && (funct == 6'h20 || funct == 6'h22 || funct == 6'h2A);
  assign w_jr    = w_rtype && funct == 6'h08;
  assign w_addi  = opcode == 6'h08;
  assign w_lw    = opcode == 6'h23;
  assign w_sw    = opcode == 6'h2B;
  assign w_beq   = opcode == 6'h04;
  assign w_bne   = opcode == 6'h05;
  assign w_j     = opcode == 6'h02;
`ifdef MULTICYCLE_CONTROL_JAL_EN
  assign w_jal   = opcode == 6'h03;
`else
  assign w_jal   = 1'b0;
`endif
  assign w_legal = w_r_alu | w_jr | w_addi | w_lw | w_sw | w_beq | w_bne | w_j | w_jal;
  // this cycle would be the max_wait-th consecutive wait cycle
  assign w_wait_hit = (r_wait == 8'(max_wait - 1)) && !mem_ready;
  // next state, fault capture and datapath controls decoded from state and IR fields
  always_comb begin
    w_next = r_state;
    w_fault = r_fault;
    w_pc_we = 1'b0;
    w_ir_we = 1'b0;
    w_a_we = 1'b0;
    w_b_we = 1'b0;
    w_aluout_we = 1'b0;
    w_mdr_we = 1'b0;
    w_rf_we = 1'b0;
    w_mem_req = 1'b0;
    w_mem_we = 1'b0;
    alu_op = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    pc_src = 2'd0;
    rf_dst = 2'd0;
    rf_src = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next = S_DECODE;
        end else if (w_wait_hit) begin
          w_next = S_HALT;
          w_fault = 2'd2;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_next = S_HALT;
          w_fault = 2'd1;
        end else begin
          w_a_we = 1'b1;
          w_b_we = 1'b1;
          w_aluout_we = 1'b1;
          alu_src_b = 2'd3;
          w_next = S_EXEC;
          if (w_j || w_jal) begin
            w_pc_we = 1'b1;
            pc_src = 2'd2;
            w_next = S_FETCH;
          end
          if (w_jal) begin
            w_rf_we = 1'b1;
            rf_dst = 2'd2;
            rf_src = 2'd2;
          end
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (w_r_alu) begin
          alu_src_a = 1'b1;
          alu_op = funct == 6'h22 ? 2'd1 : funct == 6'h2A ? 2'd2 : 2'd0;
          w_aluout_we = 1'b1;
          w_next = S_WB;
        end else if (w_addi || w_lw || w_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          w_aluout_we = 1'b1;
          w_next = w_addi ? S_WB : S_MEM;
        end else if (w_beq || w_bne) begin
          alu_src_a = 1'b1;
          alu_op = 2'd1;
          pc_src = 2'd1;
          w_pc_we = w_beq ? zero : !zero;
        end else if (w_jr) begin
          w_pc_we = 1'b1;
          pc_src = 2'd3;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we = w_sw;
        if (mem_ready) begin
          w_mdr_we = w_lw;
          w_next = w_lw ? S_WB : S_FETCH;
        end else if (w_wait_hit) begin
          w_next = S_HALT;
          w_fault = 2'd2;
        end
      end
      S_WB: begin
        w_rf_we = 1'b1;
        rf_dst = w_r_alu ? 2'd1 : 2'd0;
        rf_src = w_lw ? 2'd1 : 2'd0;
        w_next = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: begin
        w_next = S_HALT;
        w_fault = 2'd1;
      end
    endcase
  end
  // state, sticky fault and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_fault <= 2'd0;
      r_wait <= 8'd0;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault;
      r_wait <= ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready && w_next == r_state) ? r_wait + 8'd1 : 8'd0;
    end
  end
  assign pc_we = w_pc_we && !reset;
  assign ir_we = w_ir_we && !reset;
  assign a_we = w_a_we && !reset;
  assign b_we = w_b_we && !reset;
  assign aluout_we = w_aluout_we && !reset;
  assign mdr_we = w_mdr_we && !reset;
  assign rf_we = w_rf_we && !reset;
  assign mem_req = w_mem_req && !reset;
  assign mem_we = w_mem_we && !reset;
  assign state = r_state;
  assign halted = r_state == S_HALT;
  assign fault_code = r_fault;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: cycle-table and corner-sequence checks of multicycle_control (max_wait=4, JAL disabled)
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_we, ir_we, a_we, b_we, aluout_we, mdr_we, rf_we, mem_req, mem_we, alu_src_a, halted;
  logic [1:0] alu_op, alu_src_b, pc_src, rf_dst, rf_src, fault_code;
  logic [2:0] state;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic rst;
    logic [5:0] op, fn;
    logic z, rdy;
    logic [2:0] st;
    logic [6:0] we;
    logic [1:0] mem, aop;
    logic sa;
    logic [1:0] sb, ps, rd, rs, flt;
  } vec_t;
  vec_t vecs[$];
  vec_t sb_q[$];
  multicycle_control #(.max_wait(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .a_we(a_we), .b_we(b_we), .aluout_we(aluout_we), .mdr_we(mdr_we),
    .rf_we(rf_we), .mem_req(mem_req), .mem_we(mem_we), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .rf_dst(rf_dst), .rf_src(rf_src), .state(state),
    .halted(halted), .fault_code(fault_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask
  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                     input logic [2:0] st, input logic [6:0] we, input logic [1:0] mem, input logic [1:0] aop,
                     input logic sa, input logic [1:0] sb, input logic [1:0] ps, input logic [1:0] rd,
                     input logic [1:0] rs, input logic [1:0] flt);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.we = we; v.mem = mem;
    v.aop = aop; v.sa = sa; v.sb = sb; v.ps = ps; v.rd = rd; v.rs = rs; v.flt = flt;
    vecs.push_back(v);
  endtask
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic z);
    add(0, op, fn, z, 1, 3'd0, 7'b1100000, 2'b10, 0, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic dec(input logic [5:0] op, input logic [5:0] fn, input logic z);
    add(0, op, fn, z, 1, 3'd1, 7'b0011100, 2'b00, 0, 0, 3, 0, 0, 0, 0);
  endtask
  initial begin
    vec_t e;
    int n;
    // ADD: enables ordered {pc, ir, a, b, aluout, mdr, rf}
    fetch(0, 6'h20, 0); dec(0, 6'h20, 0);
    add(0, 0, 6'h20, 0, 1, 3'd2, 7'b0000100, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 6'h20, 0, 1, 3'd4, 7'b0000001, 0, 0, 0, 0, 0, 1, 0, 0);
    // ADDI
    fetch(6'h08, 0, 0); dec(6'h08, 0, 0);
    add(0, 6'h08, 0, 0, 1, 3'd2, 7'b0000100, 0, 0, 1, 2, 0, 0, 0, 0);
    add(0, 6'h08, 0, 0, 1, 3'd4, 7'b0000001, 0, 0, 0, 0, 0, 0, 0, 0);
    // LW with two wait cycles in MEM
    fetch(6'h23, 0, 0); dec(6'h23, 0, 0);
    add(0, 6'h23, 0, 0, 1, 3'd2, 7'b0000100, 0, 0, 1, 2, 0, 0, 0, 0);
    add(0, 6'h23, 0, 0, 0, 3'd3, 7'b0000000, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 0, 0, 3'd3, 7'b0000000, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 0, 1, 3'd3, 7'b0000010, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 0, 1, 3'd4, 7'b0000001, 0, 0, 0, 0, 0, 0, 1, 0);
    // SW
    fetch(6'h2B, 0, 0); dec(6'h2B, 0, 0);
    add(0, 6'h2B, 0, 0, 1, 3'd2, 7'b0000100, 0, 0, 1, 2, 0, 0, 0, 0);
    add(0, 6'h2B, 0, 0, 1, 3'd3, 7'b0000000, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    // BEQ not taken, BNE taken, BEQ taken
    fetch(6'h04, 0, 0); dec(6'h04, 0, 0);
    add(0, 6'h04, 0, 0, 1, 3'd2, 7'b0000000, 0, 1, 1, 0, 1, 0, 0, 0);
    fetch(6'h05, 0, 0); dec(6'h05, 0, 0);
    add(0, 6'h05, 0, 0, 1, 3'd2, 7'b1000000, 0, 1, 1, 0, 1, 0, 0, 0);
    fetch(6'h04, 0, 1); dec(6'h04, 0, 1);
    add(0, 6'h04, 0, 1, 1, 3'd2, 7'b1000000, 0, 1, 1, 0, 1, 0, 0, 0);
    // J
    fetch(6'h02, 0, 0);
    add(0, 6'h02, 0, 0, 1, 3'd1, 7'b1011100, 0, 0, 0, 3, 2, 0, 0, 0);
    // JR
    fetch(0, 6'h08, 0); dec(0, 6'h08, 0);
    add(0, 0, 6'h08, 0, 1, 3'd2, 7'b1000000, 0, 0, 0, 0, 3, 0, 0, 0);
    // SLT
    fetch(0, 6'h2A, 0); dec(0, 6'h2A, 0);
    add(0, 0, 6'h2A, 0, 1, 3'd2, 7'b0000100, 0, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 6'h2A, 0, 1, 3'd4, 7'b0000001, 0, 0, 0, 0, 0, 1, 0, 0);
    // SUB, then reset held three cycles starting in WB
    fetch(0, 6'h22, 0); dec(0, 6'h22, 0);
    add(0, 0, 6'h22, 0, 1, 3'd2, 7'b0000100, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h22, 0, 1, 3'd4, 7'b0000000, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 6'h22, 0, 1, 3'd0, 7'b0000000, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 6'h22, 0, 1, 3'd0, 7'b0000000, 0, 0, 0, 1, 0, 0, 0, 0);
    // FETCH timeout after four wait cycles
    for (int i = 0; i < 4; i++) add(0, 6'h3F, 0, 0, 0, 3'd0, 7'b0000000, 2'b10, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'h3F, 0, 0, 0, 3'd5, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 6'h3F, 0, 0, 1, 3'd5, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 6'h3F, 0, 0, 1, 3'd5, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 2);
    // ready on the fourth FETCH cycle, then illegal opcode 0x3F
    for (int i = 0; i < 3; i++) add(0, 6'h3F, 0, 0, 0, 3'd0, 7'b0000000, 2'b10, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'h3F, 0, 0, 1, 3'd0, 7'b1100000, 2'b10, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'h3F, 0, 0, 1, 3'd1, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h3F, 0, 0, 1, 3'd5, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 6'h3F, 0, 0, 1, 3'd5, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 1);
    // JAL opcode is illegal without the feature macro
    fetch(6'h03, 0, 0);
    add(0, 6'h03, 0, 0, 1, 3'd1, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h03, 0, 0, 1, 3'd5, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      sb_q.push_back(vecs[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      chk("state", i, 32'(state), 32'(e.st));
      chk("write_enables", i, 32'({pc_we, ir_we, a_we, b_we, aluout_we, mdr_we, rf_we}), 32'(e.we));
      chk("mem_req_we", i, 32'({mem_req, mem_we}), 32'(e.mem));
      chk("selects", i, 32'({alu_op, alu_src_a, alu_src_b, pc_src, rf_dst, rf_src}),
          32'({e.aop, e.sa, e.sb, e.ps, e.rd, e.rs}));
      chk("fault_code", i, 32'(fault_code), 32'(e.flt));
      chk("halted", i, 32'(halted), 32'(e.st == 3'd5));
      @(posedge clk); #1;
    end
    // bounded wait for the FETCH timeout to halt the FSM
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0; n = 0;
    while (!halted && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycles", 100, 32'(n), 32'd4);
    chk("timeout_fault", 100, 32'(fault_code), 32'd2);
    // MEM: ready arriving on the limit cycle completes the load without a fault
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mem_limit_state", 101, 32'(state), 32'd3);
    chk("mem_limit_mdr_we", 101, 32'(mdr_we), 32'd1);
    @(posedge clk); #1;
    chk("mem_limit_wb", 101, 32'(state), 32'd4);
    chk("mem_limit_no_fault", 101, 32'(fault_code), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
